call_ret_sequencer: RTL and testbench

CALL_RET_SEQUENCER -- requirements
Module: call_ret_sequencer

---
 rtl/cps_pkg.sv | 24 ++
 rtl/ras_store.sv | 24 ++
 rtl/call_ret_sequencer.sv | 137 +++++++++++++
 tb/tb_call_ret_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cps_pkg.sv
// Shared types for the call/return sequencer: op codes, FSM states, fault codes.
package cps_pkg;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_HALT = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RET_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_OVERFLOW  = 2'd1;
  localparam logic [1:0] FC_UNDERFLOW = 2'd2;
  localparam logic [1:0] FC_ILLEGAL   = 2'd3;

endpackage

// File: rtl/ras_store.sv
// Return-address storage: synchronous write, registered read. Pointer
// management lives in the caller; this block is just the array.
module ras_store #(
  parameter int AW    = 16,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_addr,
  output logic [AW-1:0] rd_data
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/call_ret_sequencer.sv
// Program-counter sequencer with a hardware return-address stack.
//   state       | meaning
//   ST_IDLE     | halted or after reset, waiting for start
//   ST_RUN      | consuming ops whenever instr_valid && !stall
//   ST_RET_WAIT | stack read in flight; pc loads popped address next edge
//   ST_FAULT    | sticky error, pc/depth frozen until start or reset
module call_ret_sequencer
  import cps_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            RAS_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AW-1:0]                  start_pc,
  input  logic                           instr_valid,
  input  logic [2:0]                     op,
  input  logic [AW-1:0]                  target,
  input  logic                           stall,
  output logic [AW-1:0]                  pc,
  output logic                           fetch_en,
  output logic                           busy,
  output logic                           done,
  output logic                           fault,
  output logic [1:0]                     fault_code,
  output logic [$clog2(RAS_DEPTH):0]     depth
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int DW = IW + 1;

  state_t        state;
  op_t           op_dec;
  logic          consume;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] pc_inc;
  logic [IW-1:0] rd_addr;
  logic [AW-1:0] ret_addr;

  assign op_dec   = op_t'(op);
  assign consume  = (state == ST_RUN) && instr_valid && !stall;
  assign full     = (depth == DW'(RAS_DEPTH));
  assign empty    = (depth == '0);
  assign pc_inc   = pc + 1'b1;
  assign push     = consume && (op_dec == OP_CALL) && !full;
  assign pop      = consume && (op_dec == OP_RET) && !empty;
  // Low bits wrap correctly even when depth == RAS_DEPTH.
  assign rd_addr  = depth[IW-1:0] - 1'b1;

  assign fetch_en = (state == ST_RUN) && !stall;
  assign busy     = (state == ST_RUN) || (state == ST_RET_WAIT);

  ras_store #(
    .AW   (AW),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .wr_en  (push && !reset),
    .wr_addr(depth[IW-1:0]),
    .wr_data(pc_inc),
    .rd_en  (pop),
    .rd_addr(rd_addr),
    .rd_data(ret_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      depth      <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FAULT: begin
          if (start) begin
            pc         <= start_pc;
            depth      <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (consume) begin
            case (op_dec)
              OP_SEQ: pc <= pc_inc;
              OP_JMP: pc <= target;
              OP_CALL: begin
                if (full) begin
                  fault      <= 1'b1;
                  fault_code <= FC_OVERFLOW;
                  state      <= ST_FAULT;
                end else begin
                  pc    <= target;
                  depth <= depth + 1'b1;
                end
              end
              OP_RET: begin
                if (empty) begin
                  fault      <= 1'b1;
                  fault_code <= FC_UNDERFLOW;
                  state      <= ST_FAULT;
                end else begin
                  state <= ST_RET_WAIT;
                end
              end
              OP_HALT: begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
              default: begin
                fault      <= 1'b1;
                fault_code <= FC_ILLEGAL;
                state      <= ST_FAULT;
              end
            endcase
          end
        end
        ST_RET_WAIT: begin
          pc    <= ret_addr;
          depth <= depth - 1'b1;
          state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Directed and random checks of call_ret_sequencer against a queue-based model.
module tb_call_ret_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, instr_valid, stall;
  logic [15:0] start_pc, target, pc;
  logic [2:0]  op;
  logic        fetch_en, busy, done, fault;
  logic [1:0]  fault_code;
  logic [3:0]  depth;

  int checks = 0;
  int errors = 0;

  call_ret_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .instr_valid(instr_valid), .op(op), .target(target), .stall(stall),
    .pc(pc), .fetch_en(fetch_en), .busy(busy), .done(done),
    .fault(fault), .fault_code(fault_code), .depth(depth)
  );

  always #5 clk = ~clk;

  // model state: 0 idle, 1 run, 2 waiting on return pop, 3 fault
  int          m_state;
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic [15:0] m_pend;
  logic        m_done, m_fault;
  logic [1:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input logic st, input logic [15:0] spc,
                       input logic iv, input logic [2:0] o, input logic [15:0] tg,
                       input logic stl);
    m_done = 1'b0;
    if (rst) begin
      m_state = 0; m_pc = 16'h0; m_stack.delete(); m_fault = 0; m_code = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (st) begin
        m_state = 1; m_pc = spc; m_stack.delete(); m_fault = 0; m_code = 0;
      end
    end else if (m_state == 2) begin
      m_pc = m_pend; void'(m_stack.pop_back()); m_state = 1;
    end else if (iv && !stl) begin
      if (o == 3'd0) m_pc = m_pc + 16'd1;
      else if (o == 3'd1) m_pc = tg;
      else if (o == 3'd2) begin
        if (m_stack.size() < 8) begin
          m_stack.push_back(m_pc + 16'd1); m_pc = tg;
        end else begin
          m_state = 3; m_fault = 1; m_code = 2'd1;
        end
      end else if (o == 3'd3) begin
        if (m_stack.size() > 0) begin
          m_pend = m_stack[$]; m_state = 2;
        end else begin
          m_state = 3; m_fault = 1; m_code = 2'd2;
        end
      end else if (o == 3'd4) begin
        m_state = 0; m_done = 1;
      end else begin
        m_state = 3; m_fault = 1; m_code = 2'd3;
      end
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check state.
  task automatic step(input logic rst, input logic st, input logic [15:0] spc,
                      input logic iv, input logic [2:0] o, input logic [15:0] tg,
                      input logic stl);
    reset = rst; start = st; start_pc = spc; instr_valid = iv;
    op = o; target = tg; stall = stl;
    #1;
    chk("fetch_en", fetch_en, (m_state == 1) && !stl);
    model(rst, st, spc, iv, o, tg, stl);
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("depth", depth, m_stack.size());
    chk("done", done, m_done);
    chk("fault", fault, m_fault);
    chk("fault_code", fault_code, m_code);
    chk("busy", busy, (m_state == 1) || (m_state == 2));
  endtask

  initial begin
    logic [2:0] ro;
    int r;
    m_state = 0; m_pc = 0; m_pend = 0; m_done = 0; m_fault = 0; m_code = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16'h55, 1, 0, 0, 0);
    chk("rst_pc", pc, 16'h0);
    chk("rst_busy", busy, 1'b0);

    // start, SEQ, SEQ, HALT
    step(0, 1, 16'h0010, 0, 0, 0, 0);  chk("start_pc", pc, 16'h0010);
    step(0, 1, 16'h0099, 0, 0, 0, 0);  chk("start_ignored", pc, 16'h0010);
    step(0, 0, 0, 1, 3'd0, 0, 0);      chk("seq1", pc, 16'h0011);
    step(0, 0, 0, 1, 3'd0, 0, 0);      chk("seq2", pc, 16'h0012);
    step(0, 0, 0, 1, 3'd4, 0, 0);      chk("halt_done", done, 1'b1);
    chk("halt_pc", pc, 16'h0012);
    step(0, 0, 0, 1, 3'd0, 0, 0);      chk("done_once", done, 1'b0);

    // CALL then RET, stall during RET_WAIT must not delay the pop
    step(0, 1, 16'h0020, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd2, 16'h0100, 0); chk("call_depth", depth, 4'd1);
    chk("call_pc", pc, 16'h0100);
    step(0, 0, 0, 1, 3'd3, 0, 0);      chk("ret_wait_depth", depth, 4'd1);
    step(0, 1, 16'h0777, 1, 3'd2, 16'h0300, 1); chk("ret_pc", pc, 16'h0021);
    chk("ret_depth", depth, 4'd0);

    // overflow on ninth CALL
    step(0, 1, 16'h0000, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 1, 3'd2, 16'(i * 16), 0);
    chk("ovf_fault", fault, 1'b1);
    chk("ovf_code", fault_code, 2'd1);
    chk("ovf_depth", depth, 4'd8);
    chk("ovf_pc", pc, 16'h0080);
    // unwind two levels from a fresh program to confirm LIFO order
    step(0, 1, 16'h0500, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd2, 16'h0600, 0);
    step(0, 0, 0, 1, 3'd2, 16'h0700, 0);
    step(0, 0, 0, 1, 3'd3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);         chk("lifo1", pc, 16'h0601);
    step(0, 0, 0, 1, 3'd3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);         chk("lifo2", pc, 16'h0501);

    // underflow, then restart clears the fault
    step(0, 0, 0, 1, 3'd3, 0, 0);      chk("udf_code", fault_code, 2'd2);
    step(0, 1, 16'h0040, 0, 0, 0, 0);  chk("restart_fault", fault, 1'b0);
    chk("restart_pc", pc, 16'h0040);
    chk("restart_run", busy, 1'b1);

    // pc wrap and stalled CALL
    step(0, 0, 0, 1, 3'd1, 16'hFFFF, 0);
    step(0, 0, 0, 1, 3'd0, 0, 0);      chk("wrap_pc", pc, 16'h0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3'd2, 16'h0200, 1);
    chk("stall_depth", depth, 4'd0);
    step(0, 0, 0, 1, 3'd2, 16'h0200, 0); chk("unstall_depth", depth, 4'd1);

    // reset during RET_WAIT, then illegal op
    step(0, 0, 0, 1, 3'd3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);         chk("rst_rw_pc", pc, 16'h0000);
    chk("rst_rw_depth", depth, 4'd0);
    chk("rst_rw_busy", busy, 1'b0);
    step(0, 1, 16'h0030, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd6, 0, 0);      chk("illegal_code", fault_code, 2'd3);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      ro = 3'd0;
      else if (r < 50) ro = 3'd1;
      else if (r < 70) ro = 3'd2;
      else if (r < 88) ro = 3'd3;
      else if (r < 95) ro = 3'd4;
      else             ro = 3'($urandom_range(5, 7));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 3) != 0, ro, 16'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
